// File: rtl/jhash_key_packer.sv
// jhash_key_packer: byte-stream key collector feeding the Jenkins hash stage.
// Packs key bytes little-endian into 64-bit words, buffers the whole key,
// then streams it contiguously on id/ce/last/len and waits for hash_done.
// Optional build macro JHASH_PAD3_EN rounds len up to a multiple of 3 words
// and appends all-zero padding words after the real ones.

module jhash_key_packer #(
   parameter int unsigned MAX_WORDS = 64,
   parameter int unsigned AW        = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        hash_done,
   output logic [63:0] id,
   output logic        ce,
   output logic        last,
   output logic [11:0] len,
   output logic        busy,
   output logic        err_oversize
);

   localparam int unsigned DW = 64;
   localparam int unsigned CW = 12;
   localparam int unsigned BW = 3;
`ifdef JHASH_PAD3_EN
   localparam int unsigned CAP_WORDS = (MAX_WORDS / 3) * 3;
`else
   localparam int unsigned CAP_WORDS = MAX_WORDS;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [CW-1:0]   word_cnt_q, word_cnt_d;
   logic [CW-1:0]   rd_idx_q, rd_idx_d;
   logic [DW-1:0]   asm_q, asm_d;
   logic            ovf_q, ovf_d;

   logic [DW-1:0]   id_d;
   logic            ce_d;
   logic            last_d;
   logic [CW-1:0]   len_d;
   logic            busy_d;
   logic            err_d;
   logic            s_ready_d;

   logic [DW-1:0]   key_mem [MAX_WORDS];

   logic            xfer_c;
   logic [DW-1:0]   asm_word_c;
   logic [CW-1:0]   nwords_c;
   logic [CW-1:0]   plen_c;
   logic            land_ovf_c;
   logic [CW-1:0]   rd_nxt_c;
   logic [DW-1:0]   rd_word_c;
   logic            mem_we_c;
   logic [AW-1:0]   mem_waddr_c;

   // Round a word count up to the emitted length (padding only when enabled).
   function automatic logic [CW-1:0] pad_len(input logic [CW-1:0] n);
`ifdef JHASH_PAD3_EN
      logic [CW-1:0] r;
      r = n % CW'(3);
      pad_len = (r == '0) ? n : n + (CW'(3) - r);
`else
      pad_len = n;
`endif
   endfunction

   // Datapath helpers: incoming byte merged into the word being assembled.
   // A fresh word (byte_cnt 0) starts from zero so partial words are zero-filled.
   assign xfer_c      = s_valid & s_ready;
   assign asm_word_c  = ((byte_cnt_q == '0) ? '0 : asm_q)
                        | (DW'(s_data) << {byte_cnt_q, 3'b000});
   assign nwords_c    = word_cnt_q + CW'(1);
   assign plen_c      = pad_len(nwords_c);
   assign land_ovf_c  = ovf_q | (word_cnt_q >= CW'(CAP_WORDS));
   assign rd_nxt_c    = rd_idx_q + CW'(1);
   assign rd_word_c   = (rd_nxt_c < word_cnt_q) ? key_mem[AW'(rd_nxt_c)] : '0;
   assign mem_waddr_c = AW'(word_cnt_q);

   // Key buffer write port; contents need no reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         key_mem[mem_waddr_c] <= asm_word_c;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         word_cnt_q   <= '0;
         rd_idx_q     <= '0;
         asm_q        <= '0;
         ovf_q        <= 1'b0;
         id           <= '0;
         ce           <= 1'b0;
         last         <= 1'b0;
         len          <= '0;
         busy         <= 1'b0;
         err_oversize <= 1'b0;
         s_ready      <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         word_cnt_q   <= word_cnt_d;
         rd_idx_q     <= rd_idx_d;
         asm_q        <= asm_d;
         ovf_q        <= ovf_d;
         id           <= id_d;
         ce           <= ce_d;
         last         <= last_d;
         len          <= len_d;
         busy         <= busy_d;
         err_oversize <= err_d;
         s_ready      <= s_ready_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      rd_idx_d   = rd_idx_q;
      asm_d      = asm_q;
      ovf_d      = ovf_q;
      id_d       = id;
      ce_d       = 1'b0;
      last_d     = 1'b0;
      len_d      = len;
      err_d      = 1'b0;
      mem_we_c   = 1'b0;

      case (state_q)
         ST_IDLE, ST_FILL: begin
            if (xfer_c) begin
               if (land_ovf_c) begin
                  // Oversize key: swallow bytes until s_last, then report and drop.
                  ovf_d   = 1'b1;
                  state_d = ST_FILL;
                  if (s_last) begin
                     err_d      = 1'b1;
                     state_d    = ST_IDLE;
                     ovf_d      = 1'b0;
                     byte_cnt_d = '0;
                     word_cnt_d = '0;
                  end
               end else begin
                  asm_d      = asm_word_c;
                  byte_cnt_d = byte_cnt_q + BW'(1);
                  state_d    = ST_FILL;
                  if ((byte_cnt_q == BW'(7)) || s_last) begin
                     mem_we_c   = 1'b1;
                     word_cnt_d = nwords_c;
                     byte_cnt_d = '0;
                  end
                  if (s_last) begin
                     // Launch the first word now so ce rises the next cycle;
                     // word 0 bypasses the buffer when it is written this cycle.
                     state_d  = ST_DRAIN;
                     len_d    = plen_c;
                     rd_idx_d = '0;
                     ce_d     = 1'b1;
                     last_d   = (plen_c == CW'(1));
                     id_d     = (word_cnt_q == '0) ? asm_word_c : key_mem[0];
                  end
               end
            end
         end

         ST_DRAIN: begin
            if (last) begin
               state_d = ST_WAIT;
            end else begin
               ce_d     = 1'b1;
               rd_idx_d = rd_nxt_c;
               id_d     = rd_word_c;
               last_d   = ((rd_idx_q + CW'(2)) == len);
            end
         end

         ST_WAIT: begin
            if (hash_done) begin
               state_d    = ST_IDLE;
               byte_cnt_d = '0;
               word_cnt_d = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      s_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
      busy_d    = (state_d == ST_DRAIN) || (state_d == ST_WAIT);
   end

endmodule

// File: tb/tb_jhash_key_packer.sv
// Self-checking bench for jhash_key_packer: table of keys driven through a
// byte-stream driver, words scored against a queue-based model.
`timescale 1ns/1ps

module tb_jhash_key_packer;

   localparam int unsigned MAX_WORDS = 64;
   localparam int unsigned AW        = 6;
`ifdef JHASH_PAD3_EN
   localparam int CAP = (MAX_WORDS / 3) * 3;
`else
   localparam int CAP = MAX_WORDS;
`endif
   localparam int BOUND = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic        hash_done;
   logic        hd_auto;
   logic        hd_manual;
   logic [63:0] id;
   logic        ce;
   logic        last;
   logic [11:0] len;
   logic        busy;
   logic        err_oversize;

   always #5 clk = ~clk;
   assign hash_done = hd_auto | hd_manual;

   jhash_key_packer #(.MAX_WORDS(MAX_WORDS), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .hash_done(hash_done),
      .id(id), .ce(ce), .last(last), .len(len),
      .busy(busy), .err_oversize(err_oversize)
   );

   typedef struct {
      logic [63:0] id;
      logic        last;
      logic [11:0] len;
   } exp_t;

   typedef struct {
      int          nbytes;
      logic [7:0]  base;
      logic [7:0]  step;
      bit          gaps;
      int          exp_words;
      logic [63:0] exp_w0;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[8];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          ce_seen = 0;
   int          err_cnt = 0;
   logic [63:0] first_id = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic int cfg_len(input int w);
`ifdef JHASH_PAD3_EN
      return ((w + 2) / 3) * 3;
`else
      return w;
`endif
   endfunction

   function automatic logic [7:0] key_byte(input logic [7:0] base, input logic [7:0] step, input int k);
      logic [7:0] kb;
      logic [7:0] r;
      kb = 8'(k);
      r  = base + kb * step;
      return r;
   endfunction

   // Push the expected word stream for one key, then drive its bytes.
   task automatic send_key(input int n, input logic [7:0] base, input logic [7:0] step,
                           input bit gaps, input bit hold);
      int          words;
      int          plen;
      bit          ovf;
      bit          acc;
      int          k;
      int          cyc;
      exp_t        e;
      words = (n + 7) / 8;
      ovf   = (words > CAP);
      if (!ovf) begin
         plen = cfg_len(words);
         for (int i = 0; i < plen; i++) begin
            e.id = '0;
            if (i < words) begin
               for (int j = 0; j < 8; j++) begin
                  if (8 * i + j < n) e.id[8*j +: 8] = key_byte(base, step, 8 * i + j);
               end
            end
            e.last = (i == plen - 1);
            e.len  = 12'(plen);
            exp_q.push_back(e);
         end
      end
      k   = 0;
      cyc = 0;
      while (k < n && cyc < BOUND) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = key_byte(base, step, k);
            s_last  = (k == n - 1);
         end
         acc = s_valid && s_ready;
         @(posedge clk);
         if (acc) k++;
         cyc++;
      end
      if (k < n) chk("send_timeout", 64'(k), 64'(n));
      @(negedge clk);
      chk("post_last_err", 64'(err_oversize), 64'(ovf));
      chk("post_last_ce", 64'(ce), 64'(!ovf));
      s_last = 1'b0;
      if (!hold) s_valid = 1'b0;
      if (ovf) begin
         @(negedge clk);
         chk("err_one_cycle", 64'(err_oversize), 64'd0);
         chk("ovf_s_ready", 64'(s_ready), 64'd1);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < BOUND) begin
         @(negedge clk);
         t++;
      end
      if (t >= BOUND) chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   // Output monitor: scoreboard compare, contiguity and event counting.
   initial begin
      bit   pce;
      bit   plast;
      exp_t e;
      pce   = 1'b0;
      plast = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pce   = 1'b0;
            plast = 1'b0;
         end else begin
            if (err_oversize) err_cnt++;
            if (ce) begin
               if (!pce) first_id = id;
               ce_seen++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_ce", 64'(ce), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("word_id", id, e.id);
                  chk("word_last", 64'(last), 64'(e.last));
                  chk("word_len", 64'(len), 64'(e.len));
               end
            end else if (pce && !plast) begin
               chk("ce_gap", 64'(ce), 64'd1);
            end
            pce   = ce;
            plast = last;
         end
      end
   end

   // Hash-stage stand-in: answers each final word with a delayed hash_done.
   initial begin
      hd_auto = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && ce && last) begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("wait_s_ready", 64'(s_ready), 64'd0);
               chk("wait_busy", 64'(busy), 64'd1);
               chk("wait_ce", 64'(ce), 64'd0);
            end
            hd_auto = 1'b1;
            @(negedge clk);
            hd_auto = 1'b0;
            chk("done_s_ready", 64'(s_ready), 64'd1);
            chk("done_busy", 64'(busy), 64'd0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      n_mis++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      int c0;
      int e0;
      bit ovf;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; hd_manual = 1'b0;

      vecs[0] = '{1,   8'hAB, 8'h00, 1'b0, 1,  64'h00000000000000AB};
      vecs[1] = '{12,  8'h01, 8'h01, 1'b0, 2,  64'h0807060504030201};
      vecs[2] = '{8,   8'h10, 8'h11, 1'b1, 1,  64'h8776655443322110};
      vecs[3] = '{9,   8'hF0, 8'h01, 1'b0, 2,  64'hF7F6F5F4F3F2F1F0};
      vecs[4] = '{16,  8'hC3, 8'h5A, 1'b1, 2,  64'h39DF852BD1771DC3};
      vecs[5] = '{512, 8'h00, 8'h01, 1'b0, 64, 64'h0706050403020100};
      vecs[6] = '{513, 8'h00, 8'h01, 1'b0, 65, 64'h0706050403020100};
      vecs[7] = '{24,  8'hFF, 8'hFF, 1'b1, 3,  64'hF8F9FAFBFCFDFEFF};

      repeat (3) @(negedge clk);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_id", id, 64'd0);
      chk("rst_ce", 64'(ce), 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      chk("rst_len", 64'(len), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err_oversize), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_s_ready", 64'(s_ready), 64'd1);

      // hash_done outside WAIT has no effect
      hd_manual = 1'b1;
      @(negedge clk);
      hd_manual = 1'b0;
      @(negedge clk);
      chk("stray_done_s_ready", 64'(s_ready), 64'd1);
      chk("stray_done_busy", 64'(busy), 64'd0);
      chk("stray_done_ce", 64'(ce), 64'd0);

      for (int i = 0; i < 8; i++) begin
         c0  = ce_seen;
         e0  = err_cnt;
         ovf = (vecs[i].exp_words > CAP);
         send_key(vecs[i].nbytes, vecs[i].base, vecs[i].step, vecs[i].gaps, 1'b0);
         wait_idle();
         chk($sformatf("row%0d_ce_count", i), 64'(ce_seen - c0),
             ovf ? 64'd0 : 64'(cfg_len(vecs[i].exp_words)));
         chk($sformatf("row%0d_err_count", i), 64'(err_cnt - e0), 64'(ovf));
         if (!ovf) chk($sformatf("row%0d_w0", i), first_id, vecs[i].exp_w0);
      end

      // Back-to-back keys with s_valid held high across DRAIN/WAIT
      c0 = ce_seen;
      send_key(12, 8'h01, 8'h01, 1'b0, 1'b1);
      send_key(20, 8'h80, 8'h03, 1'b0, 1'b0);
      wait_idle();
      chk("b2b_ce_count", 64'(ce_seen - c0), 64'(cfg_len(2) + cfg_len(3)));
      chk("b2b_w0", first_id, 64'h95928F8C89868380);

      // Reset asserted while the third of eight words is on the bus
      send_key(64, 8'h40, 8'h01, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("arst_ce", 64'(ce), 64'd0);
      chk("arst_last", 64'(last), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_s_ready", 64'(s_ready), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      c0 = ce_seen;
      send_key(8, 8'h01, 8'h01, 1'b0, 1'b0);
      wait_idle();
      chk("post_rst_ce_count", 64'(ce_seen - c0), 64'(cfg_len(1)));
      chk("post_rst_w0", first_id, 64'h0807060504030201);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
